// File: rtl/x7dn_word_unpacker.sv
// x7dn_word_unpacker: buffers 15-bit words and emits each as three 5-bit beats, LSB beat first.
module x7dn_word_unpacker #(
  parameter int DEPTH  = 4,
  parameter int BEAT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3*BEAT_W-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BEAT_W-1:0]         out_data,
  output logic [1:0]                out_idx,
  output logic                      out_last,
  output logic                      out_par,
  output logic [7:0]                word_cnt,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDX0, IDX1, IDX2} state_t;
  state_t state;
  logic [3*BEAT_W-1:0] mem [DEPTH];
  logic [3*BEAT_W-1:0] head;
  logic [AW-1:0] wptr, rptr;
  logic push, beat, pop;
  assign in_ready  = level != LW'(DEPTH);
  assign out_valid = level != '0;
  assign push      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && state == IDX2;
  assign head      = mem[rptr];
  assign out_idx   = state;
  assign out_last  = state == IDX2;
  assign out_data  = state == IDX0 ? head[BEAT_W-1:0] :
                     state == IDX1 ? head[2*BEAT_W-1:BEAT_W] : head[3*BEAT_W-1:2*BEAT_W];
  assign out_par   = ^out_data;
  // Storage is never reset; it is only observed while out_valid is high.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDX0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      word_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr     <= rptr + 1'b1;
        word_cnt <= word_cnt + 8'd1;
      end
      if (beat) state <= state == IDX0 ? IDX1 : state == IDX1 ? IDX2 : IDX0;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: tb/tb_x7dn_word_unpacker.sv
// tb_x7dn_word_unpacker: directed steps with a word scoreboard checked every falling edge.
module tb_x7dn_word_unpacker;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [14:0] in_data = '0;
  logic in_ready, out_valid, out_last, out_par;
  logic [4:0] out_data;
  logic [1:0] out_idx;
  logic [7:0] word_cnt;
  logic [2:0] level;
  int total = 0, passed = 0;
  logic [14:0] q[$];
  int m_idx = 0;
  logic [7:0] m_cnt = 0;
  bit bp = 0;

  x7dn_word_unpacker #(.DEPTH(DEPTH), .BEAT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_par(out_par), .word_cnt(word_cnt), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [14:0] w;
    logic [4:0] b;
    bit do_pop, do_push;
    if (!rst_n) begin
      q.delete();
      m_idx = 0;
      m_cnt = 0;
    end else begin
      chk("level", level, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() != DEPTH);
      chk("out_idx", out_idx, m_idx);
      chk("out_last", out_last, m_idx == 2);
      chk("word_cnt", word_cnt, m_cnt);
      if (q.size() != 0) begin
        w = q[0];
        b = 5'(w >> (5 * m_idx));
        chk("out_data", out_data, b);
        chk("out_par", out_par, ^b);
      end
      do_pop  = q.size() != 0 && out_ready;
      do_push = in_valid && q.size() != DEPTH;
      if (do_pop) begin
        if (m_idx == 2) begin
          m_idx = 0;
          void'(q.pop_front());
          m_cnt++;
        end else m_idx++;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [14:0] w);
    int n = 0;
    in_valid = 1;
    in_data = w;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    chk("push_timeout", n < 2000, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (level != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain", level, 0);
  endtask

  task automatic do_reset;
    rst_n = 0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    logic [14:0] w;
    tick();
    do_reset();
    // single word, full-rate consumer
    out_ready = 1;
    push(15'h5A3C);
    chk("b0_data", out_data, 5'h1C); chk("b0_par", out_par, 1); chk("b0_idx", out_idx, 0);
    tick();
    chk("b1_data", out_data, 5'h11); chk("b1_par", out_par, 0); chk("b1_idx", out_idx, 1);
    tick();
    chk("b2_data", out_data, 5'h16); chk("b2_par", out_par, 1); chk("b2_last", out_last, 1);
    tick();
    chk("single_cnt", word_cnt, 1);
    chk("single_level", level, 0);
    // fill, then hold a fifth word until a pop frees space
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) push(15'(16'h1111 * (i + 1)));
    chk("fill_level", level, DEPTH);
    chk("fill_ready", in_ready, 0);
    in_valid = 1;
    in_data = 15'h7ABC;
    repeat (4) tick();
    chk("held_level", level, DEPTH);
    out_ready = 1;
    push(15'h7ABC);
    drain();
    // random backpressure over 100 words
    bp = 1;
    for (int i = 0; i < 100; i++) push(15'($urandom));
    bp = 0;
    out_ready = 1;
    drain();
    // concurrent push/pop at level 2
    out_ready = 0;
    push(15'h0123);
    push(15'h4567);
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      chk("conc_level", level, 2);
      in_valid = out_idx == 2;
      in_data = 15'($urandom);
      tick();
    end
    in_valid = 0;
    drain();
    // reset mid-word with level 3
    out_ready = 0;
    for (int i = 0; i < 3; i++) push(15'(16'h2222 + i));
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("mid_idx", out_idx, 1);
    chk("mid_level", level, 3);
    do_reset();
    w = 15'h3D5B;
    push(w);
    chk("post_rst_idx", out_idx, 0);
    chk("post_rst_data", out_data, w[4:0]);
    out_ready = 1;
    drain();
    chk("post_rst_cnt", word_cnt, 1);
    // 257 words wrap the word counter
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 257; i++) push(15'(i * 97));
    drain();
    chk("wrap_cnt", word_cnt, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
